// File: rtl/conv_mem_read_arbiter.sv
// Two-requester read arbiter for the convolution BRAM: grants one request per cycle,
// registers it onto the memory port and steers returned words back in issue order.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed priority (F wins) instead of round-robin.
module conv_mem_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_valid,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ready,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_rdata_valid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_rdata_valid,
  output logic [15:0]           f_grant_cnt,
  output logic [15:0]           i_grant_cnt
);

  typedef enum logic {GNT_F = 1'b0, GNT_I = 1'b1} grant_e;

  grant_e                  last_grant_q, last_grant_d;
  logic                    f_hs, i_hs;
  logic                    mem_en_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [RD_LATENCY:0]     tag_vld_q;
  logic [RD_LATENCY:0]     tag_is_i_q;
  logic [DATA_WIDTH-1:0]   f_rdata_q, i_rdata_q;
  logic                    f_rdata_valid_q, i_rdata_valid_q;
  logic [15:0]             f_cnt_q, i_cnt_q;

  // State register: the requester granted most recently.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) last_grant_q <= GNT_I;
    else     last_grant_q <= last_grant_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults assigned first so no path leaves a variable unassigned (no latch).
    last_grant_d = last_grant_q;
    if (f_hs)      last_grant_d = GNT_F;
    else if (i_hs) last_grant_d = GNT_I;
  end

  // Output logic: zero-latency grant decision, suppressed while in reset.
  always_comb begin
    f_ready = 1'b0;
    i_ready = 1'b0;
    if (!rst) begin
      if (f_valid && i_valid) begin
`ifdef ARB_FIXED_PRIO_EN
        f_ready = 1'b1;
`else
        f_ready = (last_grant_q == GNT_I);
        i_ready = (last_grant_q == GNT_F);
`endif
      end else begin
        f_ready = f_valid;
        i_ready = i_valid;
      end
    end
  end

  assign f_hs = f_valid && f_ready;
  assign i_hs = i_valid && i_ready;

  always_comb begin
    mem_addr_d = mem_addr_q;
    if (f_hs)      mem_addr_d = f_addr;
    else if (i_hs) mem_addr_d = i_addr;
  end

  // Issue stage and tag pipeline; stage RD_LATENCY lines up with valid mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      // NOTE: the tag pipeline is reset so reads in flight at reset never surface.
      tag_vld_q  <= '0;
      tag_is_i_q <= '0;
    end else begin
      mem_en_q   <= f_hs || i_hs;
      mem_addr_q <= mem_addr_d;
      tag_vld_q  <= {tag_vld_q[RD_LATENCY-1:0], f_hs || i_hs};
      tag_is_i_q <= {tag_is_i_q[RD_LATENCY-1:0], i_hs};
    end
  end

  // Return stage: capture into the owning requester's register, the other one holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rdata_q       <= '0;
      i_rdata_q       <= '0;
      f_rdata_valid_q <= 1'b0;
      i_rdata_valid_q <= 1'b0;
    end else begin
      f_rdata_valid_q <= tag_vld_q[RD_LATENCY] && !tag_is_i_q[RD_LATENCY];
      i_rdata_valid_q <= tag_vld_q[RD_LATENCY] &&  tag_is_i_q[RD_LATENCY];
      if (tag_vld_q[RD_LATENCY] && !tag_is_i_q[RD_LATENCY]) f_rdata_q <= mem_rdata;
      if (tag_vld_q[RD_LATENCY] &&  tag_is_i_q[RD_LATENCY]) i_rdata_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_cnt_q <= '0;
      i_cnt_q <= '0;
    end else begin
      if (f_hs) f_cnt_q <= f_cnt_q + 16'd1;
      if (i_hs) i_cnt_q <= i_cnt_q + 16'd1;
    end
  end

  assign mem_en        = mem_en_q;
  assign mem_addr      = mem_addr_q;
  assign f_rdata       = f_rdata_q;
  assign i_rdata       = i_rdata_q;
  assign f_rdata_valid = f_rdata_valid_q;
  assign i_rdata_valid = i_rdata_valid_q;
  assign f_grant_cnt   = f_cnt_q;
  assign i_grant_cnt   = i_cnt_q;

endmodule

// File: tb/tb_conv_mem_read_arbiter.sv
// Scoreboard bench for conv_mem_read_arbiter: a rule-level model predicts grants,
// issue-port contents and return order; a separate monitor checks every return pulse.
module tb_conv_mem_read_arbiter;
  localparam int AW     = 32;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_valid = 1'b0, i_valid = 1'b0;
  logic [AW-1:0] f_addr = '0, i_addr = '0;
  logic          f_ready, i_ready, mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata, f_rdata, i_rdata;
  logic          f_rdata_valid, i_rdata_valid;
  logic [15:0]   f_grant_cnt, i_grant_cnt;

  conv_mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .f_rdata(f_rdata), .f_rdata_valid(f_rdata_valid),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .f_grant_cnt(f_grant_cnt), .i_grant_cnt(i_grant_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: word = address low byte, RD_LAT cycles after the enable is sampled.
  logic [DW-1:0] bram_pipe [RD_LAT];
  initial for (int k = 0; k < RD_LAT; k++) bram_pipe[k] = '0;
  always @(posedge clk) begin
    if (mem_en) bram_pipe[0] <= mem_addr[7:0];
    for (int k = 1; k < RD_LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign mem_rdata = bram_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          is_f;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state, starting at reset values.
  logic          m_last_f   = 1'b0;
  logic          m_mem_en   = 1'b0;
  logic [AW-1:0] m_mem_addr = '0;
  logic [15:0]   m_fcnt     = '0;
  logic [15:0]   m_icnt     = '0;
  logic          ef, ei;

  // Issue side: compare predicted registered state, predict this cycle's grant, push expectations.
  always @(negedge clk) begin
    check("mem_en", {31'd0, mem_en}, {31'd0, m_mem_en});
    check("mem_addr", mem_addr, m_mem_addr);
    check("f_grant_cnt", {16'd0, f_grant_cnt}, {16'd0, m_fcnt});
    check("i_grant_cnt", {16'd0, i_grant_cnt}, {16'd0, m_icnt});
    ef = 1'b0;
    ei = 1'b0;
    if (!rst) begin
      if (f_valid && i_valid) begin
`ifdef ARB_FIXED_PRIO_EN
        ef = 1'b1;
`else
        ef = !m_last_f;
`endif
        ei = !ef;
      end else begin
        ef = f_valid;
        ei = i_valid;
      end
    end
    check("f_ready", {31'd0, f_ready}, {31'd0, ef});
    check("i_ready", {31'd0, i_ready}, {31'd0, ei});
    if (rst) begin
      m_last_f   = 1'b0;
      m_mem_en   = 1'b0;
      m_mem_addr = '0;
      m_fcnt     = '0;
      m_icnt     = '0;
    end else begin
      m_mem_en = ef || ei;
      if (ef) begin
        m_mem_addr = f_addr;
        m_last_f   = 1'b1;
        m_fcnt     = m_fcnt + 16'd1;
        exp_q.push_back('{1'b1, f_addr[7:0], cyc + 2 + RD_LAT});
      end
      if (ei) begin
        m_mem_addr = i_addr;
        m_last_f   = 1'b0;
        m_icnt     = m_icnt + 16'd1;
        exp_q.push_back('{1'b0, i_addr[7:0], cyc + 2 + RD_LAT});
      end
    end
  end

  // Return monitor: every pulse pops the oldest expectation; rdata registers must hold otherwise.
  logic [DW-1:0] h_f = '0, h_i = '0;
  exp_t          e;
  always @(negedge clk) begin
    if (f_rdata_valid || i_rdata_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_return", {30'd0, f_rdata_valid, i_rdata_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ret_f_valid", {31'd0, f_rdata_valid}, {31'd0, e.is_f});
        check("ret_i_valid", {31'd0, i_rdata_valid}, {31'd0, !e.is_f});
        check("ret_cycle", cyc, e.due);
        if (e.is_f) h_f = e.data;
        else        h_i = e.data;
      end
    end
    check("f_rdata", {24'd0, f_rdata}, {24'd0, h_f});
    check("i_rdata", {24'd0, i_rdata}, {24'd0, h_i});
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      check("missed_return", exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (rst) begin
      exp_q.delete();
      h_f = '0;
      h_i = '0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    f_valid = 1'b1;
    i_valid = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    f_valid = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    f_valid = 1'b0;
    i_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  // Each requester issues its own run of consecutive addresses, holding valid until granted.
  task automatic run_stream(input int nf, input logic [AW-1:0] fb,
                            input int ni, input logic [AW-1:0] ib);
    int sf = 0;
    int si = 0;
    int guard = 0;
    while ((sf < nf || si < ni) && guard < nf + ni + 4) begin
      f_valid = (sf < nf);
      f_addr  = fb + AW'(sf);
      i_valid = (si < ni);
      i_addr  = ib + AW'(si);
      @(negedge clk);
      if (f_valid && f_ready) sf++;
      if (i_valid && i_ready) si++;
      next_cycle();
      guard++;
    end
    f_valid = 1'b0;
    i_valid = 1'b0;
    check("stream_complete", {31'd0, (sf == nf) && (si == ni)}, 32'd1);
  endtask

  task automatic random_phase(input int n);
    logic hf, hi;
    f_valid = 1'b0;
    i_valid = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!f_valid) begin
        f_valid = 1'($urandom_range(0, 1));
        f_addr  = $urandom;
      end
      if (!i_valid) begin
        i_valid = 1'($urandom_range(0, 1));
        i_addr  = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      hf = f_valid && f_ready;
      hi = i_valid && i_ready;
      next_cycle();
      if (hf) f_valid = 1'b0;
      if (hi) i_valid = 1'b0;
    end
    rst = 1'b0;
    f_valid = 1'b0;
    i_valid = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("reset_f_rdata_valid", {31'd0, f_rdata_valid}, 32'd0);
    check("reset_i_rdata_valid", {31'd0, i_rdata_valid}, 32'd0);
    next_cycle();

    // Single F request.
    run_stream(1, 32'h10, 0, 32'h0);
    idle(RD_LAT + 4);

    // Contention from reset: F first, then strict alternation.
    do_reset();
    run_stream(4, 32'h100, 4, 32'h200);
    idle(RD_LAT + 4);

    // I alone, back-to-back.
    run_stream(0, 32'h0, 8, 32'h0);
    idle(RD_LAT + 4);

    // Reset two cycles after an F handshake discards the in-flight read.
    run_stream(1, 32'h55, 0, 32'h0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("post_rst_mem_addr", mem_addr, 32'd0);
    check("post_rst_f_rdata", {24'd0, f_rdata}, 32'd0);
    check("post_rst_f_rdata_valid", {31'd0, f_rdata_valid}, 32'd0);
    check("post_rst_f_cnt", {16'd0, f_grant_cnt}, 32'd0);
    next_cycle();
    idle(RD_LAT + 4);

    // Grant counters.
    do_reset();
    run_stream(5, 32'h300, 3, 32'h400);
    @(negedge clk);
    check("f_cnt_five", {16'd0, f_grant_cnt}, 32'd5);
    check("i_cnt_three", {16'd0, i_grant_cnt}, 32'd3);
    next_cycle();
    idle(RD_LAT + 4);

    random_phase(2000);
    idle(RD_LAT + 4);

    // Counter wrap after 65536 F grants.
    do_reset();
    run_stream(65536, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("f_cnt_wrap", {16'd0, f_grant_cnt}, 32'd0);
    next_cycle();
    idle(RD_LAT + 6);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
